// File: rtl/fetch_dual.sv
// Dual-issue instruction fetch stage: 8-byte requests to imem, a small pair queue,
// and queue-head presentation to the IF/ID register with stall and redirect handling.
module fetch_dual #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           redirect,
    input  logic [31:0]                    redirect_pc,
    output logic                           imem_req,
    output logic [31:0]                    imem_addr,
    input  logic                           imem_ready,
    input  logic [31:0]                    imem_rdata_0,
    input  logic [31:0]                    imem_rdata_1,
    output logic [31:0]                    PC_4,
    output logic [31:0]                    Instrucction,
    output logic [31:0]                    PC_8,
    output logic [31:0]                    Instrucction_2,
    output logic                           fetch_valid,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
    } entry_t;

    state_t         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    kill_addr_q, kill_addr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    entry_t         q_mem_q [QUEUE_DEPTH];
    entry_t         q_mem_d [QUEUE_DEPTH];

    logic           push;
    logic           pop;
    logic [31:0]    redirect_pc_al;
    entry_t         head;
    logic           unused_rpc_bits;

    assign redirect_pc_al  = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_bits = ^redirect_pc[1:0];

    // Redirect outranks both push and pop: the whole queue is discarded that cycle.
    assign push = (state_q == REQ) && imem_ready && !redirect;
    assign pop  = (count_q != '0) && !stall && !redirect;

    always_comb begin
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        q_mem_d     = q_mem_q;

        if (push) begin
            q_mem_d[wr_ptr_q] = '{pc: pc_q, i0: imem_rdata_0, i1: imem_rdata_1};
        end

        if (redirect) begin
            pc_d     = redirect_pc_al;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            // The unanswered request keeps its address on the bus until memory responds.
            if ((state_q == REQ) && !imem_ready) begin
                kill_addr_d = pc_q;
            end
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd8;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (redirect || (count_q < FULL)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_d = imem_ready ? REQ : KILL;
                end else if (imem_ready) begin
                    state_d = (count_d < FULL) ? REQ : IDLE;
                end
            end
            KILL: begin
                if (imem_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= REQ;
            pc_q        <= {RESET_PC[31:2], 2'b00};
            kill_addr_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        q_mem_q <= q_mem_d;
    end

    assign head = q_mem_q[rd_ptr_q];

    always_comb begin
        imem_req       = (state_q != IDLE) && !reset;
        imem_addr      = (state_q == KILL) ? kill_addr_q : pc_q;
        fetch_valid    = (count_q != '0);
        queue_count    = count_q;
        PC_4           = '0;
        PC_8           = '0;
        Instrucction   = '0;
        Instrucction_2 = '0;
        if (fetch_valid) begin
            PC_4           = head.pc + 32'd4;
            PC_8           = head.pc + 32'd8;
            Instrucction   = head.i0;
            Instrucction_2 = head.i1;
        end
    end

endmodule

// File: tb/tb_fetch_dual.sv
// Bench for fetch_dual: scoreboarded streaming phase, a per-cycle vector table, and reset-in-KILL.
module tb_fetch_dual;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, imem_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, fetch_valid;
    logic [31:0] imem_addr, imem_rdata_0, imem_rdata_1;
    logic [31:0] PC_4, Instrucction, PC_8, Instrucction_2;
    logic [2:0]  queue_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Memory image: the word at address a is ~a.
    assign imem_rdata_0 = ~imem_addr;
    assign imem_rdata_1 = ~(imem_addr + 32'd4);

    fetch_dual #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata_0(imem_rdata_0), .imem_rdata_1(imem_rdata_1),
        .PC_4(PC_4), .Instrucction(Instrucction), .PC_8(PC_8),
        .Instrucction_2(Instrucction_2), .fetch_valid(fetch_valid), .queue_count(queue_count)
    );

    typedef struct {
        logic        s, r, rd;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        fv;
        logic [2:0]  cnt;
        logic [31:0] pc4;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mk(logic s, logic r, logic rd, logic [31:0] rpc, logic req,
                                logic [31:0] addr, logic fv, logic [2:0] cnt, logic [31:0] pc4);
        vec_t v;
        v.s = s; v.r = r; v.rd = rd; v.rpc = rpc; v.req = req;
        v.addr = addr; v.fv = fv; v.cnt = cnt; v.pc4 = pc4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_head(input string tag, input logic fv, input logic [31:0] pc4);
        chk({tag, " PC_4"}, PC_4, fv ? pc4 : 32'h0);
        chk({tag, " PC_8"}, PC_8, fv ? pc4 + 32'd4 : 32'h0);
        chk({tag, " instr0"}, Instrucction, fv ? ~(pc4 - 32'd4) : 32'h0);
        chk({tag, " instr1"}, Instrucction_2, fv ? ~pc4 : 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst fetch_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst count", {29'b0, queue_count}, 32'd0);
        chk_head("rst", 1'b0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] sb_q [$];
        logic [31:0] exp_pc;
        logic [31:0] hd;
        logic        m_idle, exp_req, do_push, do_pop;
        int unsigned cnt;

        do_reset();

        // Scoreboard phase: full speed first, then random stall/ready.
        exp_pc = 32'h0;
        m_idle = 1'b0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            stall      = (cyc < 8) ? 1'b0 : ($urandom_range(0, 3) == 0);
            imem_ready = (cyc < 8) ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            cnt     = sb_q.size();
            exp_req = !m_idle;
            do_push = exp_req && imem_ready;
            do_pop  = (cnt != 0) && !stall;
            chk("sb count", {29'b0, queue_count}, cnt);
            chk("sb fetch_valid", {31'b0, fetch_valid}, {31'b0, cnt != 0});
            chk("sb imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            if (do_pop) begin
                hd = sb_q.pop_front();
                chk_head("sb", 1'b1, hd + 32'd4);
            end
            if (do_push) begin
                chk("sb imem_addr", imem_addr, exp_pc);
                sb_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd8;
            end
            if (m_idle) m_idle = (cnt >= DEPTH);
            else if (do_push) m_idle = (cnt + 1 - (do_pop ? 1 : 0) >= DEPTH);
            @(posedge clk); #1;
        end
        chk("sb pairs fetched", {31'b0, exp_pc >= 32'h180}, 32'd1);

        // Vector table: stall fill, delayed ready, redirects, wrap.
        tbl[0]  = mk(1,1,0,32'h0,        1,32'h00,       0,0,32'h0);
        tbl[1]  = mk(1,1,0,32'h0,        1,32'h08,       1,1,32'h4);
        tbl[2]  = mk(1,1,0,32'h0,        1,32'h10,       1,2,32'h4);
        tbl[3]  = mk(1,1,0,32'h0,        1,32'h18,       1,3,32'h4);
        tbl[4]  = mk(1,1,0,32'h0,        0,32'h20,       1,4,32'h4);
        tbl[5]  = mk(1,1,0,32'h0,        0,32'h20,       1,4,32'h4);
        tbl[6]  = mk(0,1,0,32'h0,        0,32'h20,       1,4,32'h4);
        tbl[7]  = mk(0,1,0,32'h0,        0,32'h20,       1,3,32'hC);
        tbl[8]  = mk(0,1,0,32'h0,        1,32'h20,       1,2,32'h14);
        tbl[9]  = mk(0,1,0,32'h0,        1,32'h28,       1,2,32'h1C);
        tbl[10] = mk(0,1,0,32'h0,        1,32'h30,       1,2,32'h24);
        tbl[11] = mk(0,0,0,32'h0,        1,32'h38,       1,2,32'h2C);
        tbl[12] = mk(1,0,0,32'h0,        1,32'h38,       1,1,32'h34);
        tbl[13] = mk(1,0,0,32'h0,        1,32'h38,       1,1,32'h34);
        tbl[14] = mk(1,1,0,32'h0,        1,32'h38,       1,1,32'h34);
        tbl[15] = mk(1,0,1,32'h1003,     1,32'h40,       1,2,32'h34);
        tbl[16] = mk(0,0,0,32'h0,        1,32'h40,       0,0,32'h0);
        tbl[17] = mk(0,1,0,32'h0,        1,32'h40,       0,0,32'h0);
        tbl[18] = mk(0,1,0,32'h0,        1,32'h1000,     0,0,32'h0);
        tbl[19] = mk(0,0,0,32'h0,        1,32'h1008,     1,1,32'h1004);
        tbl[20] = mk(1,1,0,32'h0,        1,32'h1008,     0,0,32'h0);
        tbl[21] = mk(1,1,0,32'h0,        1,32'h1010,     1,1,32'h100C);
        tbl[22] = mk(1,1,1,32'h2000,     1,32'h1018,     1,2,32'h100C);
        tbl[23] = mk(1,1,1,32'hFFFF_FFF8,1,32'h2000,     0,0,32'h0);
        tbl[24] = mk(1,1,0,32'h0,        1,32'hFFFF_FFF8,0,0,32'h0);
        tbl[25] = mk(1,0,1,32'h3000,     1,32'h0,        1,1,32'hFFFF_FFFC);
        tbl[26] = mk(1,1,0,32'h0,        1,32'h0,        0,0,32'h0);
        tbl[27] = mk(1,0,1,32'h5000,     1,32'h3000,     0,0,32'h0);
        tbl[28] = mk(1,0,0,32'h0,        1,32'h3000,     0,0,32'h0);

        do_reset();
        for (int i = 0; i < 29; i++) begin
            stall = tbl[i].s; imem_ready = tbl[i].r;
            redirect = tbl[i].rd; redirect_pc = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
            chk($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("v%0d fetch_valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].fv});
            chk($sformatf("v%0d count", i), {29'b0, queue_count}, {29'b0, tbl[i].cnt});
            chk_head($sformatf("v%0d", i), tbl[i].fv, tbl[i].pc4);
            @(posedge clk); #1;
        end

        // Reset while a killed request is outstanding at 0x3000.
        redirect = 1'b0; reset = 1'b1; imem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("kr imem_req", {31'b0, imem_req}, 32'd0);
        chk("kr imem_addr", imem_addr, 32'h0);
        chk("kr count", {29'b0, queue_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("kr req after", {31'b0, imem_req}, 32'd1);
        chk("kr addr after", imem_addr, 32'h0);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(negedge clk);
        chk("kr fetch_valid", {31'b0, fetch_valid}, 32'd1);
        chk("kr count after", {29'b0, queue_count}, 32'd1);
        chk_head("kr", 1'b1, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_dual.md
# fetch_dual

Dual-issue instruction fetch stage for the superscalar core, directly upstream of the IF/ID pipeline register. Issues 8-byte fetch requests (two consecutive 32-bit instructions) to instruction memory over a req/ready handshake, buffers returned pairs in a small queue, and presents the queue head on the IF/ID input bus. Honors the IF/ID stall (hold) signal and supports branch redirect with queue flush and squashing of in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `QUEUE_DEPTH`, default 4: instruction-pair queue entries; power of 2, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  same polarity as IF/ID enable: 1 = downstream holding, no pop.
- `redirect`  in  1  branch/jump redirect strobe, one cycle.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] forced to 0 internally.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address (first instruction of pair).
- `imem_ready`  in  1  memory returns data this cycle for the current request.
- `imem_rdata_0`  in  32  instruction at imem_addr.
- `imem_rdata_1`  in  32  instruction at imem_addr+4.
- `PC_4`  out  32  head PC + 4.
- `Instrucction`  out  32  head first instruction.
- `PC_8`  out  32  head PC + 8.
- `Instrucction_2`  out  32  head second instruction.
- `fetch_valid`  out  1  queue non-empty; head outputs are real.
- `queue_count`  out  $clog2(QUEUE_DEPTH)+1  current occupancy.

## Operation
- Registers: `pc` (next fetch address), `kill_addr`, FSM state, queue (PC + two instructions per entry), read/write pointers, count.
- FSM states: IDLE (queue full, no request), REQ (request `pc` outstanding), KILL (request at `kill_addr` outstanding; response will be discarded).
- `imem_req` = (state != IDLE) && !reset. `imem_addr` = `pc` in REQ/IDLE, `kill_addr` in KILL. Address stable while `imem_req` high until `imem_ready`.
- Push: state REQ && `imem_ready` && !`redirect` → write {pc, rdata_0, rdata_1} at tail; `pc` <= `pc` + 8 (mod 2^32).
- Pop: `fetch_valid` && !`stall` && !`redirect` → advance head.
- Push and pop same cycle: count unchanged, both pointers advance.
- Transitions (no redirect): IDLE→REQ when count < QUEUE_DEPTH; REQ stays REQ until `imem_ready`; after push, REQ if next count < QUEUE_DEPTH else IDLE.
- Redirect (priority over push/pop): queue flushed (count=0, pointers=0), `pc` <= {redirect_pc[31:2],2'b00}. From IDLE → REQ. From REQ with `imem_ready` → REQ (response discarded). From REQ without `imem_ready` → KILL, `kill_addr` <= old `pc`. From KILL: stay KILL, `pc` updated again; if `imem_ready` same cycle → REQ.
- KILL with `imem_ready` (no redirect): response discarded, → REQ.
- Queue never overflows: single outstanding request, issued only when count < QUEUE_DEPTH.
- Empty queue: `fetch_valid`=0, `Instrucction`=`Instrucction_2`=32'h0 (NOP bubble), `PC_4`=`PC_8`=32'h0.

## Timing
- Reset (asserted at an edge): state REQ, `pc`=RESET_PC, queue empty; outputs: `imem_req`=0 during reset, `imem_addr`=RESET_PC, `fetch_valid`=0, `queue_count`=0, all PC/instruction outputs 0.
- First cycle after reset release: `imem_req`=1, `imem_addr`=RESET_PC.
- Fetch latency: `imem_ready` in cycle N → pair on outputs with `fetch_valid`=1 in cycle N+1.
- Throughput: one pair per cycle with `imem_ready` held high and no stall.
- Outputs are combinational from queue head registers; stable while `stall`=1.
- Redirect in cycle N: outputs show NOP, `fetch_valid`=0 in N+1; new-PC request in N+1 (or after the killed response).
- Reset mid-operation overrides everything, including pending KILL.

## Test plan
- Reset, RESET_PC=0, `imem_ready`=1 always, no stall → cycle 1 addr 0x0, cycle 2 outputs PC_4=0x4, PC_8=0x8; subsequent addrs 0x8, 0x10, ... one pair per cycle.
- Hold `stall`=1 from start, ready=1 → exactly 4 pushes, `queue_count`=4, `imem_req`=0 (IDLE); release stall → pops in order, requests resume at 0x20.
- `imem_ready` delayed 3 cycles → `imem_addr` stable for all 3 cycles, `fetch_valid` rises cycle after ready.
- Redirect to 0x1003 while REQ outstanding (ready low) → state KILL, `imem_addr` stays old, queue flushed; killed data not enqueued; next request addr 0x1000; first output PC_4=0x1004.
- Simultaneous redirect and `imem_ready` with queue holding 2 → response dropped, count=0 next cycle, next addr = redirect_pc.
- `pc` near 0xFFFF_FFF8 → next address wraps to 0x0; reset asserted in KILL → addr RESET_PC, queue empty.
